// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares one 64-bit ALU (add/sub/and/xor) between two requesters. A round-robin
//   arbiter grants one op at a time; the op is latched, evaluated in one cycle and
//   returned through a registered response carrying the requester id. Condition
//   codes (ZF/SF/OF) are updated only by ops from requester CC_OWNER with set_cc=1.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   req{0,1}_valid/_ready     request handshake (valid & ready = transfer)
//   req{0,1}_op               00 add, 01 sub (A-B), 10 and, 11 xor
//   req{0,1}_a/_b             signed operands
//   req{0,1}_set_cc           request condition-code update with this result
//   resp_valid/resp_ready     response handshake
//   resp_id                   requester that owns the response
//   resp_result/resp_ovf      ALU result and signed overflow (0 for and/xor)
//   cc_zf/cc_sf/cc_of         architectural condition codes
//   busy                      scheduler not idle
//
// State table
//   state   | meaning
//   IDLE    | waiting for a request; arbiter drives the readies
//   EXEC    | ALU evaluates the latched op; response and CC captured on exit
//   RESP    | response held until the consumer takes it

module alu_rr_scheduler #(
    parameter int DATA_W   = 64,
    parameter int CC_OWNER = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_set_cc,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_set_cc,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_ovf,

    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam logic OWNER_ID = (CC_OWNER != 0);
    localparam int   MSB      = DATA_W - 1;

    logic [1:0]        state;
    logic              last_grant;

    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              set_cc_q;
    logic              id_q;

    logic              gnt0;
    logic              gnt1;

    logic [1:0]        sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              sel_set_cc;

    logic [DATA_W-1:0] alu_sum;
    logic [DATA_W-1:0] alu_diff;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;

    // Arbiter: only the winner sees ready. On a tie the requester that did not
    // win last time goes first; last_grant resets to 1 so req0 wins the first tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_grant) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        sel_op     = req0_op;
        sel_a      = req0_a;
        sel_b      = req0_b;
        sel_set_cc = req0_set_cc;
        if (gnt1) begin
            sel_op     = req1_op;
            sel_a      = req1_a;
            sel_b      = req1_b;
            sel_set_cc = req1_set_cc;
        end
    end

    // ALU runs only from the latched operands, so requester inputs are ignored
    // after the grant edge.
    always_comb begin
        alu_sum    = a_q + b_q;
        alu_diff   = a_q - b_q;
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_result = alu_sum;
                alu_ovf    = (a_q[MSB] == b_q[MSB]) && (alu_sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_result = alu_diff;
                alu_ovf    = (a_q[MSB] != b_q[MSB]) && (alu_diff[MSB] != a_q[MSB]);
            end
            OP_AND: begin
                alu_result = a_q & b_q;
            end
            OP_XOR: begin
                alu_result = a_q ^ b_q;
            end
            default: begin
                alu_result = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            set_cc_q    <= 1'b0;
            id_q        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_ovf    <= 1'b0;
            cc_zf       <= 1'b1;
            cc_sf       <= 1'b0;
            cc_of       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        set_cc_q   <= sel_set_cc;
                        id_q       <= gnt1;
                        last_grant <= gnt1;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_valid  <= 1'b1;
                    resp_id     <= id_q;
                    resp_result <= alu_result;
                    resp_ovf    <= alu_ovf;
                    if (set_cc_q && (id_q == OWNER_ID)) begin
                        cc_zf <= (alu_result == '0);
                        cc_sf <= alu_result[MSB];
                        cc_of <= alu_ovf;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
